// File: rtl/axis_window_buffer_pkg.sv
// rtl/axis_window_buffer_pkg.sv - mode encodings and default geometry shared with ctrl and conv blocks
package axis_window_buffer_pkg;

  // Control-mode encodings; the unused code 2'b11 is decoded as idle.
  typedef enum logic [1:0] {
    MODE_IDLE     = 2'b00,
    MODE_LOAD_W   = 2'b01,
    MODE_LOAD_IMG = 2'b10
  } mode_e;

  localparam int DEF_PIX_W  = 8;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_K      = 3;
  localparam int DEF_IMG_W  = 32;
  localparam int DEF_IMG_H  = 32;

endpackage

// File: rtl/window_line_buffer.sv
// rtl/window_line_buffer.sv - K-1 line RAMs feeding a K x K window shift register
module window_line_buffer
  import axis_window_buffer_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int K     = DEF_K,
  parameter int IMG_W = DEF_IMG_W,
  localparam int CW    = $clog2(IMG_W),
  localparam int WIN_W = K * K * PIX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic [CW-1:0]    col,
  input  logic [PIX_W-1:0] pix,
  output logic [WIN_W-1:0] win_data
);

  // line_q[0] holds the oldest buffered row, line_q[K-2] the row just above the current one.
  logic [PIX_W-1:0] line_q [K-1][IMG_W];
  logic [PIX_W-1:0] line_d [K-1];
  logic [PIX_W-1:0] new_col [K];
  logic [WIN_W-1:0] win_q, win_d;

  // Assemble the incoming column (oldest row first) and the values each line RAM inherits.
  always_comb begin
    for (int i = 0; i < K - 1; i++) new_col[i] = line_q[i][col];
    new_col[K-1] = pix;
    for (int m = 0; m < K - 1; m++) line_d[m] = new_col[m+1];
  end

  // Shift the window one column left and insert the new column on the right.
  always_comb begin
    win_d = win_q;
    if (shift_en) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++)
          win_d[(i*K+j)*PIX_W +: PIX_W] = win_q[(i*K+j+1)*PIX_W +: PIX_W];
        win_d[(i*K+K-1)*PIX_W +: PIX_W] = new_col[i];
      end
    end
    if (clr) win_d = '0;
  end

  // Window register; cleared on reset and on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) win_q <= '0;
    else        win_q <= win_d;
  end

  // Line RAMs are never reset: rows are only read once rewritten by the current frame.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      for (int m = 0; m < K - 1; m++) line_q[m][col] <= line_d[m];
    end
  end

  assign win_data = win_q;

endmodule

// File: rtl/axis_window_buffer.sv
// rtl/axis_window_buffer.sv - AXIS weight/pixel intake emitting K x K windows; optional AXIS_WINDOW_BUFFER_TLAST_CHECK_EN
module axis_window_buffer
  import axis_window_buffer_pkg::*;
#(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int K      = DEF_K,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H
) (
  input  logic                   s_axis_aclk,
  input  logic                   s_axis_aresetn,
  input  logic [1:0]             mode,
  input  logic                   start,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_W-1:0]      s_axis_tdata,
  input  logic [DATA_W/8-1:0]    s_axis_tstrb,
  input  logic                   s_axis_tlast,
  output logic [K*K*PIX_W-1:0]   wdata,
  output logic                   wdata_v,
  output logic [K*K*PIX_W-1:0]   win_data,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic                   win_last,
  output logic                   frame_done,
  output logic                   err_tlast
);

  localparam int NW  = K * K;
  localparam int WCW = $clog2(NW);
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam logic [WCW-1:0] WC_LAST = WCW'(NW - 1);
  localparam logic [CW-1:0]  C_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0]  C_WIN   = CW'(K - 1);
  localparam logic [RW-1:0]  R_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0]  R_WIN   = RW'(K - 1);

  logic                 is_w, is_img, beat_acc, w_acc, img_acc, last_pix, win_pos;
  logic [PIX_W-1:0]     pix;
  logic [WCW-1:0]       wc_q, wc_d;
  logic [CW-1:0]        c_q, c_d;
  logic [RW-1:0]        r_q, r_d;
  logic [NW*PIX_W-1:0]  wdata_q, wdata_d;
  logic                 wdata_v_q, wdata_v_d;
  logic                 win_valid_q, win_valid_d;
  logic                 win_last_q, win_last_d;
  logic                 frame_done_q, frame_done_d;

  assign is_w          = (mode == MODE_LOAD_W);
  assign is_img        = (mode == MODE_LOAD_IMG);
  assign s_axis_tready = is_w | (is_img & (~win_valid_q | win_ready));
  assign beat_acc      = s_axis_tvalid & s_axis_tready;
  assign w_acc         = beat_acc & is_w;
  assign img_acc       = beat_acc & is_img;
  assign pix           = s_axis_tdata[PIX_W-1:0];
  assign last_pix      = (c_q == C_LAST) && (r_q == R_LAST);
  assign win_pos       = (c_q >= C_WIN) && (r_q >= R_WIN);

  // Next-state for weight store, row/column counters and the window handshake.
  always_comb begin
    wc_d         = wc_q;
    wdata_d      = wdata_q;
    wdata_v_d    = wdata_v_q;
    c_d          = c_q;
    r_d          = r_q;
    win_valid_d  = win_valid_q;
    win_last_d   = win_last_q;
    frame_done_d = 1'b0;
    if (win_valid_q && win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
    if (w_acc) begin
      wdata_d[wc_q*PIX_W +: PIX_W] = pix;
      wdata_v_d = (wc_q == WC_LAST);
      wc_d      = (wc_q == WC_LAST) ? '0 : wc_q + 1'b1;
    end
    if (img_acc) begin
      if (win_pos) begin
        win_valid_d = 1'b1;
        win_last_d  = last_pix;
      end
      frame_done_d = last_pix;
      if (c_q == C_LAST) begin
        c_d = '0;
        r_d = (r_q == R_LAST) ? '0 : r_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
    end
    if (start) begin
      wc_d = '0; wdata_d = '0; wdata_v_d = 1'b0; c_d = '0; r_d = '0;
      win_valid_d = 1'b0; win_last_d = 1'b0; frame_done_d = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      wc_q <= '0; wdata_q <= '0; wdata_v_q <= 1'b0; c_q <= '0; r_q <= '0;
      win_valid_q <= 1'b0; win_last_q <= 1'b0; frame_done_q <= 1'b0;
    end else begin
      wc_q <= wc_d; wdata_q <= wdata_d; wdata_v_q <= wdata_v_d; c_q <= c_d; r_q <= r_d;
      win_valid_q <= win_valid_d; win_last_q <= win_last_d; frame_done_q <= frame_done_d;
    end
  end

  window_line_buffer #(.PIX_W(PIX_W), .K(K), .IMG_W(IMG_W)) u_lb (
    .clk      (s_axis_aclk),
    .rst_n    (s_axis_aresetn),
    .clr      (start),
    .shift_en (img_acc & ~start),
    .col      (c_q),
    .pix      (pix),
    .win_data (win_data)
  );

  assign wdata      = wdata_q;
  assign wdata_v    = wdata_v_q;
  assign win_valid  = win_valid_q;
  assign win_last   = win_last_q;
  assign frame_done = frame_done_q;

`ifdef AXIS_WINDOW_BUFFER_TLAST_CHECK_EN
  logic err_q, err_d, last_beat;
  logic unused_bits;

  // Flag tlast on a non-final beat or missing on the final one; sticky until start.
  always_comb begin
    last_beat = is_w ? (wc_q == WC_LAST) : last_pix;
    err_d     = err_q;
    if (beat_acc && (s_axis_tlast != last_beat)) err_d = 1'b1;
    if (start) err_d = 1'b0;
  end

  // Sticky error register.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) err_q <= 1'b0;
    else                 err_q <= err_d;
  end

  assign err_tlast   = err_q;
  assign unused_bits = ^{s_axis_tstrb, s_axis_tdata[DATA_W-1:PIX_W]};
`else
  logic unused_bits;
  assign err_tlast   = 1'b0;
  assign unused_bits = ^{s_axis_tstrb, s_axis_tdata[DATA_W-1:PIX_W], s_axis_tlast};
`endif

endmodule

// File: tb/tb_axis_window_buffer.sv
// tb/tb_axis_window_buffer.sv - directed bench for axis_window_buffer (K=3, 4x4 frames)
module tb_axis_window_buffer;
  localparam int PIX_W = 8, DATA_W = 32, K = 3, IMG_W = 4, IMG_H = 4;
  localparam int WIN_W = K * K * PIX_W;
`ifdef AXIS_WINDOW_BUFFER_TLAST_CHECK_EN
  localparam bit TLAST_EN = 1'b1;
`else
  localparam bit TLAST_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic start = 1'b0, s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, win_ready = 1'b0;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic [DATA_W/8-1:0] s_axis_tstrb = '1;
  logic s_axis_tready, wdata_v, win_valid, win_last, frame_done, err_tlast;
  logic [WIN_W-1:0] wdata, win_data;

  int checks = 0, failures = 0, fd_cnt = 0;
  logic [WIN_W-1:0] got_win[$];
  bit got_last[$];

  axis_window_buffer #(.PIX_W(PIX_W), .DATA_W(DATA_W), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .mode(mode), .start(start),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tstrb(s_axis_tstrb), .s_axis_tlast(s_axis_tlast), .wdata(wdata), .wdata_v(wdata_v),
    .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready), .win_last(win_last),
    .frame_done(frame_done), .err_tlast(err_tlast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && win_valid && win_ready) begin
      got_win.push_back(win_data);
      got_last.push_back(win_last);
    end
    if (rst_n && frame_done) fd_cnt++;
  end

  function automatic logic [WIN_W-1:0] exp_win(input int base, input int r, input int c);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[(i*K+j)*PIX_W +: PIX_W] = PIX_W'(base + (r-K+1+i)*IMG_W + (c-K+1+j));
    return w;
  endfunction

  function automatic logic [WIN_W-1:0] first_win();
    int fw[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    logic [WIN_W-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*PIX_W +: PIX_W] = PIX_W'(fw[k]);
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic send(input int v, input bit last);
    int n;
    n = 0;
    s_axis_tvalid = 1'b1; s_axis_tdata = DATA_W'(v); s_axis_tlast = last;
    #1;
    while (!s_axis_tready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL send_timeout value=%0d tready=%0b required=1", v, s_axis_tready);
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(2);
    checks++; if ({win_valid, win_last, frame_done, wdata_v, err_tlast} !== 5'b0) begin failures++;
      $display("FAIL reset_flags got=%b exp=00000", {win_valid, win_last, frame_done, wdata_v, err_tlast}); end
    checks++; if (win_data !== '0) begin failures++; $display("FAIL reset_win_data got=%h exp=0", win_data); end
    checks++; if (wdata !== '0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
    rst_n = 1'b1; tick(1);
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL reset_idle_tready got=%b exp=0", s_axis_tready); end
  endtask

  task automatic test_weight_load();
    logic [WIN_W-1:0] ew;
    ew = '0;
    pulse_start(); mode = 2'b01;
    for (int v = 1; v <= 9; v++) begin
      send(v, v == 9);
      ew[(v-1)*PIX_W +: PIX_W] = PIX_W'(v);
      if (v == 8) begin checks++; if (wdata_v !== 1'b0) begin failures++;
        $display("FAIL w_valid_early got=%b exp=0", wdata_v); end end
    end
    checks++; if (wdata_v !== 1'b1) begin failures++; $display("FAIL w_valid_full got=%b exp=1", wdata_v); end
    checks++; if (wdata !== ew) begin failures++; $display("FAIL w_set got=%h exp=%h", wdata, ew); end
    send(8'hAA, 1'b0);
    ew[0 +: PIX_W] = 8'hAA;
    checks++; if (wdata_v !== 1'b0) begin failures++; $display("FAIL w_valid_drop got=%b exp=0", wdata_v); end
    checks++; if (wdata !== ew) begin failures++; $display("FAIL w_overwrite got=%h exp=%h", wdata, ew); end
    mode = 2'b00;
  endtask

  task automatic test_basic_window();
    int wb, fb;
    pulse_start(); mode = 2'b10; win_ready = 1'b1;
    wb = got_win.size(); fb = fd_cnt;
    for (int p = 0; p < 16; p++) begin
      send(p, p == 15);
      if (p == 9) begin checks++; if (win_valid !== 1'b0) begin failures++;
        $display("FAIL basic_early_valid got=%b exp=0", win_valid); end end
      if (p == 10) begin checks++; if (win_valid !== 1'b1 || win_data !== first_win()) begin failures++;
        $display("FAIL basic_first_win valid=%b got=%h exp=%h", win_valid, win_data, first_win()); end end
      if (p == 15) begin checks++; if ({win_valid, win_last, frame_done} !== 3'b111) begin failures++;
        $display("FAIL basic_frame_end got=%b exp=111", {win_valid, win_last, frame_done}); end end
    end
    tick(1);
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", frame_done); end
    tick(2);
    checks++; if (got_win.size() - wb != 4 || fd_cnt - fb != 1) begin failures++;
      $display("FAIL basic_count windows=%0d frames=%0d exp=4/1", got_win.size() - wb, fd_cnt - fb); end
    else for (int k = 0; k < 4; k++) begin
      checks++; if (got_win[wb+k] !== exp_win(0, 2 + k/2, 2 + k%2) || got_last[wb+k] !== (k == 3)) begin failures++;
        $display("FAIL basic_win%0d got=%h last=%b exp=%h", k, got_win[wb+k], got_last[wb+k], exp_win(0, 2 + k/2, 2 + k%2)); end
    end
  endtask

  task automatic test_backpressure();
    int wb, fb;
    pulse_start(); mode = 2'b10; win_ready = 1'b1;
    wb = got_win.size(); fb = fd_cnt;
    for (int p = 0; p <= 10; p++) send(p, 1'b0);
    win_ready = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = 32'd11; #1;
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL bp_tready got=%b exp=0", s_axis_tready); end
    tick(3);
    checks++; if (win_valid !== 1'b1 || win_data !== first_win()) begin failures++;
      $display("FAIL bp_hold valid=%b got=%h exp=%h", win_valid, win_data, first_win()); end
    win_ready = 1'b1;
    for (int p = 11; p < 16; p++) send(p, p == 15);
    tick(3);
    checks++; if (got_win.size() - wb != 4 || fd_cnt - fb != 1) begin failures++;
      $display("FAIL bp_count windows=%0d frames=%0d exp=4/1", got_win.size() - wb, fd_cnt - fb); end
    else for (int k = 0; k < 4; k++) begin
      checks++; if (got_win[wb+k] !== exp_win(0, 2 + k/2, 2 + k%2)) begin failures++;
        $display("FAIL bp_win%0d got=%h exp=%h", k, got_win[wb+k], exp_win(0, 2 + k/2, 2 + k%2)); end
    end
  endtask

  task automatic test_back_to_back();
    int wb, fb;
    pulse_start(); mode = 2'b10; win_ready = 1'b1;
    wb = got_win.size(); fb = fd_cnt;
    for (int p = 0; p < 32; p++) send(p, (p % 16) == 15);
    tick(3);
    checks++; if (got_win.size() - wb != 8 || fd_cnt - fb != 2) begin failures++;
      $display("FAIL b2b_count windows=%0d frames=%0d exp=8/2", got_win.size() - wb, fd_cnt - fb); end
    else for (int k = 0; k < 8; k++) begin
      checks++; if (got_win[wb+k] !== exp_win((k < 4) ? 0 : 16, 2 + (k%4)/2, 2 + k%2) || got_last[wb+k] !== (k%4 == 3)) begin
        failures++; $display("FAIL b2b_win%0d got=%h last=%b exp=%h", k, got_win[wb+k], got_last[wb+k],
                             exp_win((k < 4) ? 0 : 16, 2 + (k%4)/2, 2 + k%2)); end
    end
  endtask

  task automatic test_mid_frame_abort();
    int wb;
    pulse_start(); mode = 2'b10; win_ready = 1'b1;
    for (int p = 0; p <= 6; p++) send(200 + p, 1'b0);
    start = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 32'd99; tick(1);
    start = 1'b0; s_axis_tvalid = 1'b0;
    checks++; if (win_valid !== 1'b0 || win_data !== '0) begin failures++;
      $display("FAIL abort_clear valid=%b got=%h exp=0", win_valid, win_data); end
    wb = got_win.size();
    for (int p = 0; p < 16; p++) send(p, p == 15);
    tick(3);
    checks++; if (got_win.size() - wb != 4) begin failures++;
      $display("FAIL abort_count windows=%0d exp=4", got_win.size() - wb); end
    else for (int k = 0; k < 4; k++) begin
      checks++; if (got_win[wb+k] !== exp_win(0, 2 + k/2, 2 + k%2)) begin failures++;
        $display("FAIL abort_win%0d got=%h exp=%h", k, got_win[wb+k], exp_win(0, 2 + k/2, 2 + k%2)); end
    end
  endtask

  task automatic test_mode_switch();
    int wb;
    pulse_start(); mode = 2'b10; win_ready = 1'b1;
    wb = got_win.size();
    for (int p = 0; p < 6; p++) send(p, 1'b0);
    mode = 2'b00; #1;
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL ms_idle_tready got=%b exp=0", s_axis_tready); end
    mode = 2'b11; #1;
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL ms_mode3_tready got=%b exp=0", s_axis_tready); end
    tick(3); mode = 2'b10;
    for (int p = 6; p <= 10; p++) send(p, 1'b0);
    win_ready = 1'b0; mode = 2'b00; tick(3);
    checks++; if (win_valid !== 1'b1 || win_data !== first_win()) begin failures++;
      $display("FAIL ms_pending valid=%b got=%h exp=%h", win_valid, win_data, first_win()); end
    mode = 2'b10; win_ready = 1'b1;
    for (int p = 11; p < 16; p++) send(p, p == 15);
    tick(3);
    checks++; if (got_win.size() - wb != 4) begin failures++;
      $display("FAIL ms_count windows=%0d exp=4", got_win.size() - wb); end
    else for (int k = 0; k < 4; k++) begin
      checks++; if (got_win[wb+k] !== exp_win(0, 2 + k/2, 2 + k%2)) begin failures++;
        $display("FAIL ms_win%0d got=%h exp=%h", k, got_win[wb+k], exp_win(0, 2 + k/2, 2 + k%2)); end
    end
  endtask

  task automatic test_tlast_check();
    pulse_start(); mode = 2'b10; win_ready = 1'b1;
    for (int p = 0; p <= 7; p++) send(p, p == 7);
    checks++; if (err_tlast !== TLAST_EN) begin failures++; $display("FAIL tlast_set got=%b exp=%b", err_tlast, TLAST_EN); end
    for (int p = 8; p < 16; p++) send(p, p == 15);
    checks++; if (err_tlast !== TLAST_EN) begin failures++; $display("FAIL tlast_sticky got=%b exp=%b", err_tlast, TLAST_EN); end
    pulse_start();
    checks++; if (err_tlast !== 1'b0) begin failures++; $display("FAIL tlast_clear got=%b exp=0", err_tlast); end
  endtask

  task automatic test_async_reset();
    pulse_start(); mode = 2'b01;
    for (int v = 1; v <= 9; v++) send(v, v == 9);
    mode = 2'b10; win_ready = 1'b1;
    for (int p = 0; p <= 10; p++) send(p, 1'b0);
    win_ready = 1'b0;
    #2 rst_n = 1'b0; #1;
    checks++; if ({win_valid, win_last, frame_done, wdata_v} !== 4'b0 || win_data !== '0 || wdata !== '0) begin failures++;
      $display("FAIL async_reset flags=%b win=%h w=%h exp=0", {win_valid, win_last, frame_done, wdata_v}, win_data, wdata); end
    tick(1); rst_n = 1'b1; mode = 2'b00; tick(1);
  endtask

  initial begin
    test_reset();
    test_weight_load();
    test_basic_window();
    test_backpressure();
    test_back_to_back();
    test_mid_frame_abort();
    test_mode_switch();
    test_tlast_check();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time_limit_reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_window_buffer.md
Name: axis_window_buffer

Overview:
- Parametrised successor of the fixed 3-tap input buffer. It accepts a pixel stream on AXI4-Stream and a K*K weight set on the same stream, selected by the control mode.
- Emits one K x K sliding window per valid output position ("valid" convolution, no padding), with valid/ready backpressure toward the convolution engine.
- Sits between the AXI-Lite control block (mode/start) and the conv datapath.

Parameters:
- PIX_W, 8, bits per pixel/weight; carried in tdata[PIX_W-1:0].
- DATA_W, 32, AXIS tdata width; must be >= PIX_W.
- K, 3, window edge (K >= 2).
- IMG_W, 32, pixels per row (IMG_W >= K).
- IMG_H, 32, rows per frame (IMG_H >= K).

Ports:
- s_axis_aclk  in  1  sole clock
- s_axis_aresetn  in  1  asynchronous, active-low reset
- mode  in  2  00 IDLE, 01 LOAD_W, 10 LOAD_IMG, 11 treated as IDLE
- start  in  1  one-cycle pulse; clears all counters and the line buffers
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input beat accepted
- s_axis_tdata  in  DATA_W  bits above PIX_W are ignored
- s_axis_tstrb  in  DATA_W/8  ignored
- s_axis_tlast  in  1  end of weight set / frame
- wdata  out  K*K*PIX_W  weight w(i,j) at [(i*K+j)*PIX_W +: PIX_W]
- wdata_v  out  1  high while a complete weight set is held
- win_data  out  K*K*PIX_W  window; element (i,j) = pixel(r-K+1+i, c-K+1+j)
- win_valid  out  1  window valid
- win_ready  in  1  downstream accepts the window
- win_last  out  1  with the last window of a frame
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted
- err_tlast  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset and start: every output, counter and window register goes to 0. Line-buffer contents become don't-care and are marked invalid. start has priority over a same-cycle beat, which is dropped.
- Beat acceptance:
  - s_axis_tready is combinational.
  - LOAD_W: tready = 1.
  - LOAD_IMG: tready = !win_valid | win_ready.
  - IDLE: tready = 0.
  - A beat is accepted when tvalid & tready.
- LOAD_W:
  - The weight counter wc (0..K*K-1) writes weight wc. wdata_v drops to 0 on the first weight beat.
  - After beat K*K-1, wdata_v = 1 and wc wraps to 0. Further beats overwrite starting from weight 0.
- LOAD_IMG counters: column c (0..IMG_W-1) and row r (0..IMG_H-1) advance per accepted pixel. c wraps to 0 and increments r.
- LOAD_IMG storage:
  - K-1 row line buffers of IMG_W entries, indexed by c.
  - A K x K shift register of window columns; each new column = {line buffers at c, new pixel}.
  - Line buffers shift down one row at the same time.
- Window output:
  - When an accepted pixel has r >= K-1 and c >= K-1, win_valid is set on the next edge (latency 1) with the registered window.
  - win_valid holds with win_data stable until win_ready.
  - A new window may load in the same cycle the old one is taken.
  - Windows per frame = (IMG_H-K+1)*(IMG_W-K+1).
- Frame end: the pixel at (IMG_H-1, IMG_W-1) sets win_last with its window and pulses frame_done. Then r = c = 0, and the next frame starts without start.
- Mode changes:
  - Leaving LOAD_IMG mid-frame holds all counters and state; resuming continues the frame.
  - Switching mode never drops a pending win_valid.
- Width: counters use $clog2 of their range. No arithmetic is performed on pixel data.

Optional Feature:
- Macro AXIS_WINDOW_BUFFER_TLAST_CHECK_EN.
- Enabled: err_tlast is set, and held until reset or start, when:
  - tlast is accepted on a beat that is not the last weight (LOAD_W) or the last pixel (LOAD_IMG);
  - tlast is absent on that last beat.
- Data flow is unaffected.
- Disabled: err_tlast is tied 0 and tlast is ignored.

Decomposition:
- Shared package: mode encodings (MODE_IDLE/LOAD_W/LOAD_IMG) and the default PIX_W/K/IMG_W/IMG_H constants, also used by the ctrl and conv blocks.
- One sub-module, window_line_buffer: holds the K-1 line RAMs and the K x K shift register, driven by a shift enable and column index.
- The top level keeps mode decode, counters, handshake and the optional check.

Test Plan:
- Weight load: K=3, beats 1..9 in LOAD_W -> wdata_v=1 after the 9th beat, w(0,0)=1, w(2,2)=9. A 10th beat of 0xAA -> wdata_v=0, w(0,0)=0xAA.
- Basic window: K=3, IMG_W=IMG_H=4, pixel=r*4+c.
  - The first window appears 1 cycle after pixel 10 is accepted, equal to {0,1,2,4,5,6,8,9,10}.
  - Exactly 4 windows; win_last and frame_done with the window ending at 15.
- Backpressure: hold win_ready=0 after the first window -> tready=0, win_data stable. Release -> remaining windows in order; none lost or duplicated.
- Back-to-back frames: two frames without start -> the second frame's first window is {16..} offset values; row/col counters restart at 0.
- Mid-frame abort: start after pixel 6 then a new frame -> first window as in the basic test; no stale line data appears. Async reset mid-frame -> all outputs 0 immediately.
- With AXIS_WINDOW_BUFFER_TLAST_CHECK_EN: tlast on pixel 7 -> err_tlast=1, sticky until start. Without the macro, the same stimulus gives err_tlast=0.
